// File: rtl/linked_list_pkg.sv
// Shared op codes, master FSM states and the legality check used by the
// linked-list command master and its FIFO.
package linked_list_pkg;

  localparam logic [2:0] OP_IDLE        = 3'b000;
  localparam logic [2:0] OP_INSERT_HEAD = 3'b100;
  localparam logic [2:0] OP_INSERT_TAIL = 3'b101;
  localparam logic [2:0] OP_DELETE      = 3'b110;
  localparam logic [2:0] OP_TRAVERSE    = 3'b111;

  // FIFO entry: {op[2:0], data[7:0]}
  localparam int CMD_W = 11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HOLD = 2'd1,
    S_GAP  = 2'd2,
    S_RESP = 2'd3
  } master_state_e;

  function automatic logic is_legal_op(input logic [2:0] op);
    return (op == OP_INSERT_HEAD) || (op == OP_INSERT_TAIL) ||
           (op == OP_DELETE)      || (op == OP_TRAVERSE);
  endfunction

endpackage

// File: rtl/ll_cmd_fifo.sv
// Small synchronous FIFO buffering host commands ahead of the issue FSM.
// The read port is combinational from the head entry (show-ahead).
module ll_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 11
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign data_o  = mem_q[rd_ptr_q];

  // A full FIFO refuses a push even when a pop happens in the same cycle.
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/linked_list_cmd_master.sv
// Replays queued commands onto the linked-list operation/data_in interface as
// a held op code plus an IDLE gap, and reports per-command sticky-flag status.
module linked_list_cmd_master
  import linked_list_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int HOLD_CYCLES = 40,
  parameter int GAP_CYCLES  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_op,
  input  logic [7:0] cmd_data,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [2:0] rsp_op,
  output logic       rsp_overflow,
  output logic       rsp_underflow,
  output logic       rsp_stale,
  output logic       rsp_illegal,
  output logic [2:0] operation,
  output logic [7:0] data_in,
  input  logic       overflow,
  input  logic       underflow
);

  localparam int CNT_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  master_state_e    state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [2:0]       op_q, op_d;
  logic [7:0]       data_q, data_d;
  logic [2:0]       operation_q, operation_d;
  logic             ovf0_q, ovf0_d, unf0_q, unf0_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [2:0]       rsp_op_q, rsp_op_d;
  logic             rsp_ovf_q, rsp_ovf_d, rsp_unf_q, rsp_unf_d;
  logic             rsp_stale_q, rsp_stale_d, rsp_ill_q, rsp_ill_d;

  logic             fifo_full, fifo_empty, fifo_pop;
  logic [CMD_W-1:0] fifo_dout;

  assign cmd_ready = !fifo_full;

  ll_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (CMD_W)
  ) u_fifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .push_i  (cmd_valid && !fifo_full),
    .data_i  ({cmd_op, cmd_data}),
    .pop_i   (fifo_pop),
    .data_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      op_q        <= OP_IDLE;
      data_q      <= '0;
      operation_q <= OP_IDLE;
      ovf0_q      <= 1'b0;
      unf0_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_op_q    <= OP_IDLE;
      rsp_ovf_q   <= 1'b0;
      rsp_unf_q   <= 1'b0;
      rsp_stale_q <= 1'b0;
      rsp_ill_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      data_q      <= data_d;
      operation_q <= operation_d;
      ovf0_q      <= ovf0_d;
      unf0_q      <= unf0_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_op_q    <= rsp_op_d;
      rsp_ovf_q   <= rsp_ovf_d;
      rsp_unf_q   <= rsp_unf_d;
      rsp_stale_q <= rsp_stale_d;
      rsp_ill_q   <= rsp_ill_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    data_d      = data_q;
    operation_d = operation_q;
    ovf0_d      = ovf0_q;
    unf0_d      = unf0_q;
    rsp_valid_d = rsp_valid_q;
    rsp_op_d    = rsp_op_q;
    rsp_ovf_d   = rsp_ovf_q;
    rsp_unf_d   = rsp_unf_q;
    rsp_stale_d = rsp_stale_q;
    rsp_ill_d   = rsp_ill_q;
    fifo_pop    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!fifo_empty && !rsp_valid_q) begin
          fifo_pop = 1'b1;
          op_d     = fifo_dout[10:8];
          data_d   = fifo_dout[7:0];
          ovf0_d   = overflow;
          unf0_d   = underflow;
          cnt_d    = '0;
          if (is_legal_op(fifo_dout[10:8])) begin
            state_d     = S_HOLD;
            operation_d = fifo_dout[10:8];
          end else begin
            state_d     = S_RESP;
            rsp_op_d    = fifo_dout[10:8];
            rsp_ovf_d   = 1'b0;
            rsp_unf_d   = 1'b0;
            rsp_stale_d = 1'b0;
            rsp_ill_d   = 1'b1;
          end
        end
      end

      S_HOLD: begin
        if (cnt_q == CW'(HOLD_CYCLES - 1)) begin
          cnt_d       = '0;
          state_d     = S_GAP;
          operation_d = OP_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      // Flags are judged against the baseline on the final gap cycle, by which
      // point the list has long finished reacting to the held op code.
      S_GAP: begin
        if (cnt_q == CW'(GAP_CYCLES - 1)) begin
          cnt_d       = '0;
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          rsp_op_d    = op_q;
          rsp_ovf_d   = overflow & ~ovf0_q;
          rsp_unf_d   = underflow & ~unf0_q;
          rsp_stale_d = ovf0_q | unf0_q;
          rsp_ill_d   = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_RESP: begin
        if (!rsp_valid_q) begin
          rsp_valid_d = 1'b1;
        end else if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign operation     = operation_q;
  assign data_in       = data_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_op        = rsp_op_q;
  assign rsp_overflow  = rsp_ovf_q;
  assign rsp_underflow = rsp_unf_q;
  assign rsp_stale     = rsp_stale_q;
  assign rsp_illegal   = rsp_ill_q;

endmodule

// File: tb/tb_linked_list_cmd_master.sv
// Scoreboard bench for linked_list_cmd_master: a queue-based list model predicts
// each response at push time; a monitor checks issue windows and responses.
module tb_linked_list_cmd_master;

  localparam int FIFO_DEPTH = 4;
  localparam int HOLD       = 40;
  localparam int GAP        = 4;
  localparam int MAX_NODES  = 8;

  localparam logic [2:0] OP_IDLE_C = 3'b000;
  localparam logic [2:0] OP_HEAD_C = 3'b100;
  localparam logic [2:0] OP_TAIL_C = 3'b101;
  localparam logic [2:0] OP_DEL_C  = 3'b110;

  typedef logic [7:0] byteQ_t [$];
  typedef struct packed {
    logic [2:0] op;
    logic       ovf;
    logic       unf;
    logic       stale;
    logic       illegal;
  } rsp_t;
  typedef struct packed {
    logic [2:0] op;
    logic [7:0] data;
  } issue_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [2:0] cmd_op = 3'b000;
  logic [7:0] cmd_data = 8'h00;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [2:0] rsp_op;
  logic       rsp_overflow, rsp_underflow, rsp_stale, rsp_illegal;
  logic [2:0] operation;
  logic [7:0] data_in;
  logic       overflow = 1'b0;
  logic       underflow = 1'b0;

  int     nTests = 0;
  int     nFail = 0;
  int     cyc = 0;
  int     curRun = 0;
  int     rspMode = 0;
  rsp_t   expQ[$];
  issue_t issueQ[$];
  byteQ_t predList;
  byteQ_t physList;
  logic   predOvf = 1'b0;
  logic   predUnf = 1'b0;

  always #5 clk = ~clk;

  linked_list_cmd_master #(
    .FIFO_DEPTH  (FIFO_DEPTH),
    .HOLD_CYCLES (HOLD),
    .GAP_CYCLES  (GAP)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_op        (cmd_op),
    .cmd_data      (cmd_data),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_op        (rsp_op),
    .rsp_overflow  (rsp_overflow),
    .rsp_underflow (rsp_underflow),
    .rsp_stale     (rsp_stale),
    .rsp_illegal   (rsp_illegal),
    .operation     (operation),
    .data_in       (data_in),
    .overflow      (overflow),
    .underflow     (underflow)
  );

  function automatic void checkOutput(input string name, input logic [31:0] actual,
                                      input logic [31:0] expected);
    nTests++;
    if (actual !== expected) begin
      nFail++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, actual, expected);
    end
  endfunction

  function automatic void failNow(input string name, input logic [31:0] actual,
                                  input logic [31:0] expected);
    nTests++;
    nFail++;
    $display("[TB] FAIL %s: got %0h, required %0h", name, actual, expected);
  endfunction

  function automatic logic isLegal(input logic [2:0] op);
    return op[2];
  endfunction

  // Abstract list semantics: bounded insert, delete-first-match, sticky flags.
  function automatic void listApply(input logic [2:0] op, input logic [7:0] d,
                                    inout byteQ_t lst, inout logic ovf, inout logic unf);
    int idx;
    idx = -1;
    case (op)
      OP_HEAD_C: if (lst.size() >= MAX_NODES) ovf = 1'b1; else lst.push_front(d);
      OP_TAIL_C: if (lst.size() >= MAX_NODES) ovf = 1'b1; else lst.push_back(d);
      OP_DEL_C: begin
        if (lst.size() == 0) unf = 1'b1;
        else begin
          for (int i = 0; i < lst.size(); i++) if (idx < 0 && lst[i] == d) idx = i;
          if (idx >= 0) lst.delete(idx);
        end
      end
      default: ;
    endcase
  endfunction

  // Linked-list stand-in: acts once whenever operation changes to a non-idle code.
  initial begin
    logic [2:0] lastOp;
    lastOp = OP_IDLE_C;
    forever begin
      @(negedge clk);
      if (rst) begin
        physList.delete();
        overflow = 1'b0;
        underflow = 1'b0;
        lastOp = OP_IDLE_C;
      end else begin
        if (operation != lastOp && operation != OP_IDLE_C)
          listApply(operation, data_in, physList, overflow, underflow);
        lastOp = operation;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      rsp_ready = (rspMode == 2) ? ($urandom_range(0, 3) != 0) : (rspMode == 1);
    end
  end

  // Monitor: issue windows, response latency and response contents.
  initial begin
    logic [2:0] prevOp;
    logic       prevRsp, pendLegal;
    int         riseCyc;
    issue_t     cur;
    rsp_t       got, exp;
    prevOp = OP_IDLE_C; prevRsp = 1'b0; pendLegal = 1'b0; riseCyc = 0; cur = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        prevOp = OP_IDLE_C; prevRsp = 1'b0; pendLegal = 1'b0; curRun = 0;
      end else begin
        if (operation != OP_IDLE_C) begin
          if (prevOp == OP_IDLE_C) begin
            if (issueQ.size() == 0) failNow("unexpectedIssue", operation, OP_IDLE_C);
            else begin
              cur = issueQ.pop_front();
              checkOutput("issueOp", operation, cur.op);
              checkOutput("issueData", data_in, cur.data);
            end
            curRun = 1; riseCyc = cyc; pendLegal = 1'b1;
          end else begin
            if (operation != prevOp) failNow("opChangedInHold", operation, prevOp);
            curRun++;
          end
        end else if (prevOp != OP_IDLE_C) begin
          checkOutput("holdLength", curRun, HOLD);
          checkOutput("dataInGap", data_in, cur.data);
          curRun = 0;
        end
        if (rsp_valid && !prevRsp && pendLegal) begin
          checkOutput("rspLatency", cyc - riseCyc, HOLD + GAP);
          pendLegal = 1'b0;
        end
        if (rsp_valid && rsp_ready) begin
          got = {rsp_op, rsp_overflow, rsp_underflow, rsp_stale, rsp_illegal};
          if (expQ.size() == 0) failNow("unexpectedRsp", got, 0);
          else begin
            exp = expQ.pop_front();
            checkOutput("rspFields", got, exp);
          end
        end
        prevOp = operation;
        prevRsp = rsp_valid;
      end
    end
  end

  // Offers one command; on acceptance the predicted response is queued.
  task automatic applyStimulus(input logic [2:0] op, input logic [7:0] d);
    rsp_t e;
    logic ovf0, unf0, done;
    int   waited;
    done = 1'b0; waited = 0;
    @(posedge clk); #1;
    cmd_op = op; cmd_data = d; cmd_valid = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (cmd_ready) begin
        @(posedge clk);
        e = '0;
        e.op = op;
        if (isLegal(op)) begin
          ovf0 = predOvf; unf0 = predUnf;
          listApply(op, d, predList, predOvf, predUnf);
          e.ovf = predOvf & ~ovf0;
          e.unf = predUnf & ~unf0;
          e.stale = ovf0 | unf0;
          issueQ.push_back('{op: op, data: d});
        end else begin
          e.illegal = 1'b1;
        end
        expQ.push_back(e);
        done = 1'b1;
      end else if (waited > 3000) begin
        failNow("pushTimeout", cmd_ready, 1);
        @(posedge clk);
        done = 1'b1;
      end else begin
        waited++;
        @(posedge clk);
      end
    end
    #1 cmd_valid = 1'b0;
  endtask

  task automatic waitIdle(input int bound);
    int n;
    n = 0;
    while ((expQ.size() != 0 || issueQ.size() != 0) && n < bound) begin
      @(negedge clk);
      n++;
    end
    checkOutput("drainPending", expQ.size() + issueQ.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic resetDut();
    @(posedge clk); #1;
    rst = 1'b1;
    expQ.delete(); issueQ.delete(); predList.delete();
    predOvf = 1'b0; predUnf = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    logic [2:0] rop;
    logic       seen;
    int         n;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("resetOperation", operation, OP_IDLE_C);
    checkOutput("resetDataIn", data_in, 8'h00);
    checkOutput("resetCmdReady", cmd_ready, 1);
    checkOutput("resetRspValid", rsp_valid, 0);
    checkOutput("resetRspFields", {rsp_op, rsp_overflow, rsp_underflow, rsp_stale, rsp_illegal}, 0);

    rspMode = 1;
    applyStimulus(OP_HEAD_C, 8'h3C);
    @(negedge clk); checkOutput("opBeforeIssue", operation, OP_IDLE_C);
    @(negedge clk); checkOutput("opFirstDriven", operation, OP_HEAD_C);
    checkOutput("dataFirstDriven", data_in, 8'h3C);
    waitIdle(200);

    resetDut();
    applyStimulus(OP_DEL_C, 8'h55);
    applyStimulus(OP_DEL_C, 8'h55);
    waitIdle(300);

    resetDut();
    applyStimulus(OP_TAIL_C, 8'h11);
    applyStimulus(OP_TAIL_C, 8'h22);
    waitIdle(300);
    checkOutput("listCount", physList.size(), 2);
    if (physList.size() == 2) begin
      checkOutput("listFirst", physList[0], 8'h11);
      checkOutput("listSecond", physList[1], 8'h22);
    end

    applyStimulus(3'b011, 8'h99);
    @(negedge clk);
    @(negedge clk); checkOutput("illegalEarly", rsp_valid, 0);
    @(negedge clk); checkOutput("illegalRspValid", rsp_valid, 1);
    checkOutput("illegalNoOp", operation, OP_IDLE_C);
    waitIdle(50);

    resetDut();
    rspMode = 0;
    for (int i = 0; i < FIFO_DEPTH + 1; i++) applyStimulus(OP_HEAD_C, 8'(i + 1));
    @(negedge clk); checkOutput("fullAfterQueue", cmd_ready, 0);
    repeat (60) @(negedge clk);
    checkOutput("stillFull", cmd_ready, 0);
    checkOutput("rspHeld", rsp_valid, 1);
    @(posedge clk); #1 rspMode = 1;
    applyStimulus(OP_DEL_C, 8'h02);
    waitIdle(600);

    resetDut();
    applyStimulus(OP_HEAD_C, 8'h01);
    applyStimulus(OP_TAIL_C, 8'h02);
    applyStimulus(OP_DEL_C, 8'h01);
    n = 0;
    while (curRun != 9 && n < 200) begin @(negedge clk); n++; end
    checkOutput("reachedHold9", curRun, 9);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkOutput("midResetOperation", operation, OP_IDLE_C);
    checkOutput("midResetCmdReady", cmd_ready, 1);
    checkOutput("midResetRspValid", rsp_valid, 0);
    expQ.delete(); issueQ.delete(); predList.delete();
    predOvf = 1'b0; predUnf = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    seen = 1'b0;
    repeat (150) begin
      @(negedge clk);
      if (rsp_valid || operation != OP_IDLE_C) seen = 1'b1;
    end
    checkOutput("noActivityAfterReset", seen, 0);

    rspMode = 2;
    for (int r = 0; r < 3; r++) begin
      resetDut();
      for (int k = 0; k < 12; k++) begin
        if (r == 0) rop = 3'(4 + $urandom_range(0, 1));
        else if ($urandom_range(0, 5) == 0) rop = 3'($urandom_range(0, 3));
        else rop = 3'(4 + $urandom_range(0, 3));
        applyStimulus(rop, 8'($urandom_range(1, 6)));
        repeat ($urandom_range(0, 3)) @(posedge clk);
      end
      waitIdle(2000);
    end
    rspMode = 1;

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
